// File: rtl/prefix_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// prefix_add_seq_pkg
//
// Shared definitions for the multi-precision add/subtract sequencer.
//   ADD_W   : width of the prefix adder datapath (one word per beat)
//   state_t : sequencer state, ST_IDLE between transactions, ST_BUSY inside one
// -----------------------------------------------------------------------------
package prefix_add_seq_pkg;

  localparam int ADD_W = 30;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/prefix_add_seq_adder.sv
// -----------------------------------------------------------------------------
// adder
//
// 30-bit Knowles parallel-prefix adder in its minimum-fanout form (every level
// combines with the node one span to the right), giving log2(W) prefix levels.
//
// Ports:
//   a, b  in  ADD_W : operands
//   cin   in  1     : carry into bit 0
//   sum   out ADD_W : a + b + cin, low ADD_W bits
//   cout  out 1     : carry out of the most significant bit
// -----------------------------------------------------------------------------
module adder
  import prefix_add_seq_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum,
  output logic             cout
);

  localparam int LVLS = $clog2(ADD_W);

  logic [ADD_W-1:0] prop;
  logic [ADD_W-1:0] gg;
  logic [ADD_W-1:0] pp;
  logic [ADD_W-1:0] gn;
  logic [ADD_W-1:0] pn;

  assign prop = a ^ b;

  // Prefix tree. The carry-in is folded into bit 0's generate so that after the
  // last level gg[i] is the carry out of bit i including cin. Each level works
  // on the previous level's vectors only, so the loop describes pure wiring.
  always_comb begin
    gg = a & b;
    pp = prop;
    gn = '0;
    pn = '0;
    gg[0] = gg[0] | (pp[0] & cin);
    for (int l = 0; l < LVLS; l++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < ADD_W; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pn[i] = pp[i] & pp[i - (1 << l)];
        end
      end
      gg = gn;
      pp = pn;
    end
  end

  // Carry into bit i is the group generate of bits i-1..0 (cin for bit 0).
  assign sum  = prop ^ {gg[ADD_W-2:0], cin};
  assign cout = gg[ADD_W-1];

endmodule

// File: rtl/prefix_add_seq.sv
// -----------------------------------------------------------------------------
// prefix_add_seq
//
// Multi-precision add/subtract sequencer. Operands stream in one W-bit word per
// beat, least-significant word first; each word goes through a single prefix
// adder and the inter-word carry is held in carry_r. Results leave through a
// single registered valid/ready stage (no skid buffer).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input beat handshake
//   in_a, in_b          : operand words
//   in_first, in_last   : transaction framing
//   in_sub              : 1 = A-B, sampled on the starting beat only
//   out_valid/out_ready : result beat handshake
//   out_sum, out_cout   : result word and carry out (on subtract 1 = no borrow)
//   out_last, out_idx   : framing copy and word index within the transaction
//   out_ovf             : signed overflow, only on the last word
//   out_err             : beat carried in_first while a transaction was open
// -----------------------------------------------------------------------------
module prefix_add_seq
  import prefix_add_seq_pkg::*;
#(
  parameter int W    = 30,
  parameter int IDXW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_sum,
  output logic            out_last,
  output logic [IDXW-1:0] out_idx,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            out_err
);

  generate
    if (W != ADD_W) begin : g_width_check
      $error("prefix_add_seq: W must equal the adder width ADD_W");
    end
  endgenerate

  state_t          state_q;
  state_t          state_d;
  logic            sub_r;
  logic            carry_r;
  logic [IDXW-1:0] idx_r;

  logic            acc;
  logic            start;
  logic            abort;
  logic            sub_eff;
  logic            cin;
  logic [IDXW-1:0] idx_cur;
  logic [W-1:0]    b_eff;
  logic [W-1:0]    sum;
  logic            cout;
  logic            c_msb;

  // The stage can take a new beat whenever its output register is empty or is
  // being drained this same cycle.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;

  // Beat classification and next-state. A beat starts a fresh transaction when
  // nothing is open or when it is explicitly marked first; a first beat that
  // arrives while a transaction is open is flagged but otherwise restarts.
  always_comb begin
    state_d = state_q;
    start   = (state_q == ST_IDLE) || in_first;
    abort   = (state_q == ST_BUSY) && in_first;
    sub_eff = start ? in_sub : sub_r;
    cin     = start ? in_sub : carry_r;
    idx_cur = start ? '0 : idx_r;
    if (acc) begin
      state_d = in_last ? ST_IDLE : ST_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Subtraction is A + ~B + 1: the +1 comes in as the carry of the first word.
  assign b_eff = in_b ^ {W{sub_eff}};

  adder u_adder (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // Carry into the sign bit; signed overflow is when it disagrees with cout.
  assign c_msb = in_a[W-1] ^ b_eff[W-1] ^ sum[W-1];

  // Output register and per-transaction context. Everything only moves on an
  // accepted beat, so back-pressure freezes the whole block. A pop without a
  // new beat just empties the stage; the data is left as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
      carry_r   <= 1'b0;
      sub_r     <= 1'b0;
      idx_r     <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_last  <= in_last;
      out_idx   <= idx_cur;
      out_cout  <= cout;
      out_ovf   <= in_last & (c_msb ^ cout);
      out_err   <= abort;
      carry_r   <= cout;
      sub_r     <= sub_eff;
      idx_r     <= idx_cur + IDXW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
